// File: rtl/key_color_select_if.sv
// -----------------------------------------------------------------------------
// key_color_select_if
//
// Purpose:
//   Bundles the push-button input, the frame-start strobe and all outputs of
//   key_color_select. Clk_50MHz and Reset are not carried here; they stay
//   plain module ports.
//
// Signals:
//   Key          raw push-button, active-low, asynchronous, may bounce
//   Frame_Start  one-cycle strobe at the start of vertical blanking
//   Color_Sel    colour index currently applied to the rectangle fill
//   Next_Sel     colour index that the next Frame_Start will apply
//   Press_Pulse  one-cycle pulse per accepted (debounced) press
//   Key_Held     high while a debounced press is in effect
//   Dbg_State    encoded debounce FSM state (observation only)
//   Dbg_Count    debounce stability counter (observation only)
//
// Modports:
//   master  drives Key / Frame_Start and observes everything else
//   slave   the key_color_select side
// -----------------------------------------------------------------------------
interface key_color_select_if;
    logic        Key;
    logic        Frame_Start;
    logic [1:0]  Color_Sel;
    logic [1:0]  Next_Sel;
    logic        Press_Pulse;
    logic        Key_Held;
    logic [1:0]  Dbg_State;
    logic [19:0] Dbg_Count;

    modport master (
        output Key,
        output Frame_Start,
        input  Color_Sel,
        input  Next_Sel,
        input  Press_Pulse,
        input  Key_Held,
        input  Dbg_State,
        input  Dbg_Count
    );

    modport slave (
        input  Key,
        input  Frame_Start,
        output Color_Sel,
        output Next_Sel,
        output Press_Pulse,
        output Key_Held,
        output Dbg_State,
        output Dbg_Count
    );
endinterface

// File: rtl/key_color_select.sv
// -----------------------------------------------------------------------------
// key_color_select
//
// Purpose:
//   Debounces an active-low push-button and uses each accepted press to step
//   a fill-colour index (0=green, 1=red, 2=blue, 3=reserved). Presses
//   accumulate in Next_Sel; Color_Sel only picks up Next_Sel on Frame_Start,
//   so the displayed colour never changes in the middle of a frame.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept an edge
//                    (2 .. 2^20-1; default is 20 ms at 50 MHz)
//   NUM_COLORS       number of colours cycled through (2 .. 4)
//
// Ports:
//   Clk_50MHz  system clock, all state changes on its rising edge
//   Reset      asynchronous, active-high
//   bus        key_color_select_if.slave (Key, Frame_Start in; Color_Sel,
//              Next_Sel, Press_Pulse, Key_Held, Dbg_State, Dbg_Count out)
//
// Strobe semantics (there is no back-pressure anywhere in this block):
//   Frame_Start and Press_Pulse are single-cycle strobes that are acted on at
//   the rising edge that samples them high. A Press_Pulse visible in cycle k
//   advances Next_Sel at the edge ending cycle k; a Frame_Start in the same
//   cycle loads the value Next_Sel held before that advance.
//
// Timing:
//   With Key falling cleanly, the first edge that samples it low is edge 0.
//   The synchronizer delivers key_s low by edge 2 (IDLE -> PRESS_WAIT), the
//   counter then runs 0..DEBOUNCE_CYCLES-1, and the registered Press_Pulse
//   goes high at edge 2+DEBOUNCE_CYCLES together with entry into HELD.
// -----------------------------------------------------------------------------
module key_color_select #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_COLORS      = 3
) (
    input  logic              Clk_50MHz,
    input  logic              Reset,
    key_color_select_if.slave bus
);

    localparam int          CNT_W      = 20;
    localparam logic [19:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]  COLOR_LAST = 2'(NUM_COLORS - 1);

    // Encoding is visible on Dbg_State; keep it stable.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer. Both flops reset to 1 (button released) so that
    // leaving reset with the button already down still needs a full debounce.
    // -------------------------------------------------------------------------
    logic key_meta;
    logic key_s;

    always_ff @(posedge Clk_50MHz or posedge Reset) begin
        if (Reset) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= bus.Key;
            key_s    <= key_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM
    // -------------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_pulse;
    logic             press_nxt;

    always_ff @(posedge Clk_50MHz or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press_pulse <= press_nxt;
        end
    end

    // The counter is cleared on every transition, so it only ever counts the
    // current run of stable samples and cannot pass CNT_LAST.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    // Bounce back high: abandon this press silently.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                // Holding the button never repeats the press.
                if (key_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    // Release bounce: still the same press, no new pulse.
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Colour selection. Next_Sel accumulates presses; Color_Sel only follows it
    // on Frame_Start, reading the pre-increment value when both coincide.
    // -------------------------------------------------------------------------
    logic [1:0] next_sel;
    logic [1:0] color_sel;

    always_ff @(posedge Clk_50MHz or posedge Reset) begin
        if (Reset) begin
            next_sel <= 2'd0;
        end else if (press_pulse) begin
            next_sel <= (next_sel == COLOR_LAST) ? 2'd0 : next_sel + 2'd1;
        end
    end

    always_ff @(posedge Clk_50MHz or posedge Reset) begin
        if (Reset) begin
            color_sel <= 2'd0;
        end else if (bus.Frame_Start) begin
            color_sel <= next_sel;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.Color_Sel   = color_sel;
    assign bus.Next_Sel    = next_sel;
    assign bus.Press_Pulse = press_pulse;
    assign bus.Key_Held    = (state == HELD) || (state == RELEASE_WAIT);
    assign bus.Dbg_State   = state;
    assign bus.Dbg_Count   = cnt;

endmodule

// File: tb/tb_key_color_select.sv
module tb_key_color_select;

  localparam int D = 4;
  localparam int N = 3;

  logic Clk_50MHz = 1'b0;
  logic Reset = 1'b0;

  key_color_select_if bus ();

  key_color_select #(
    .DEBOUNCE_CYCLES(D),
    .NUM_COLORS(N)
  ) dut (
    .Clk_50MHz(Clk_50MHz),
    .Reset(Reset),
    .bus(bus.slave)
  );

  // clock / reset block
  always #10 Clk_50MHz = ~Clk_50MHz;

  int checks = 0;
  int failures = 0;
  int pulse_seen = 0;

  // ---------------------------------------------------------------------------
  // Reference model: a press is accepted when the synchronized key (raw Key
  // delayed by two edges) has been low for D+1 consecutive edges while
  // released; a release completes after D+1 consecutive high edges while
  // pressed. Any opposite sample restarts the run.
  // ---------------------------------------------------------------------------
  bit m_pressed;
  int m_run;
  bit m_pulse;
  int m_next;
  int m_color;
  bit hist_q[$];

  task automatic model_reset();
    m_pressed = 0;
    m_run = 0;
    m_pulse = 0;
    m_next = 0;
    m_color = 0;
    hist_q = {1'b1, 1'b1};
  endtask

  task automatic model_edge(input bit key, input bit fs);
    bit ks;
    bit new_pulse;
    ks = hist_q.pop_front();
    hist_q.push_back(key);
    if (fs) m_color = m_next;
    if (m_pulse) m_next = (m_next + 1) % N;
    new_pulse = 0;
    if (!m_pressed) begin
      m_run = ks ? 0 : m_run + 1;
      if (m_run == D + 1) begin
        m_pressed = 1;
        m_run = 0;
        new_pulse = 1;
      end
    end else begin
      m_run = ks ? m_run + 1 : 0;
      if (m_run == D + 1) begin
        m_pressed = 0;
        m_run = 0;
      end
    end
    m_pulse = new_pulse;
  endtask

  // ---------------------------------------------------------------------------
  // scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check_val({tag, "_pulse"}, int'(bus.Press_Pulse), int'(m_pulse));
    check_val({tag, "_next"}, int'(bus.Next_Sel), m_next);
    check_val({tag, "_color"}, int'(bus.Color_Sel), m_color);
    check_val({tag, "_held"}, int'(bus.Key_Held), int'(m_pressed));
  endtask

  // driver: inputs change at negedge, outputs sampled at the next negedge
  task automatic step(input bit key, input bit fs);
    bus.Key = key;
    bus.Frame_Start = fs;
    @(posedge Clk_50MHz);
    model_edge(key, fs);
    @(negedge Clk_50MHz);
    bus.Frame_Start = 1'b0;
    if (bus.Press_Pulse === 1'b1) pulse_seen++;
    compare_model("model");
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge Clk_50MHz);
    Reset = 1'b1;
    #1;
    check_val("rst_color", int'(bus.Color_Sel), 0);
    check_val("rst_next", int'(bus.Next_Sel), 0);
    check_val("rst_pulse", int'(bus.Press_Pulse), 0);
    check_val("rst_held", int'(bus.Key_Held), 0);
    check_val("rst_state", int'(bus.Dbg_State), 0);
    check_val("rst_count", int'(bus.Dbg_Count), 0);
    model_reset();
    bus.Frame_Start = 1'b1;
    repeat (2) @(posedge Clk_50MHz);
    @(negedge Clk_50MHz);
    bus.Frame_Start = 1'b0;
    Reset = 1'b0;
  endtask

  // Holds Key low until Press_Pulse shows; returns edges after the first low
  // sample, or -1 when the bound expires.
  task automatic measure_latency(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0);
      if (bus.Press_Pulse === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic press_release();
    repeat (8) step(1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // table-driven segments: drive {key, fs} for n cycles, then check outputs
  // ---------------------------------------------------------------------------
  typedef struct {
    bit key;
    bit fs;
    int n;
    bit e_pulse;
    int e_next;
    int e_color;
    bit e_held;
  } seg_t;

  seg_t tbl[$];

  initial begin
    int lat;
    int p0;
    int level;
    int len;

    // clean press, hold, release, frame start
    tbl.push_back('{1'b0, 1'b0, 6, 1'b0, 0, 0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1, 1'b1, 0, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1, 1'b0, 1, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 12, 1'b0, 1, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 6, 1'b0, 1, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1, 1'b0, 1, 0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1, 1'b0, 1, 1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3, 1'b0, 1, 1, 1'b0});
    // bounce: low/high every 2 cycles for 20 cycles, then high
    for (int i = 0; i < 5; i++) begin
      tbl.push_back('{1'b0, 1'b0, 2, 1'b0, 1, 1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2, 1'b0, 1, 1, 1'b0});
    end
    tbl.push_back('{1'b1, 1'b0, 4, 1'b0, 1, 1, 1'b0});

    bus.Key = 1'b1;
    bus.Frame_Start = 1'b0;
    model_reset();
    #1;
    do_reset();

    foreach (tbl[i]) begin
      repeat (tbl[i].n) step(tbl[i].key, tbl[i].fs);
      check_val($sformatf("seg%0d_pulse", i), int'(bus.Press_Pulse), int'(tbl[i].e_pulse));
      check_val($sformatf("seg%0d_next", i), int'(bus.Next_Sel), tbl[i].e_next);
      check_val($sformatf("seg%0d_color", i), int'(bus.Color_Sel), tbl[i].e_color);
      check_val($sformatf("seg%0d_held", i), int'(bus.Key_Held), int'(tbl[i].e_held));
    end
    check_val("bounce_idle", int'(bus.Dbg_State), 0);

    // latency + press/frame coincidence (Next_Sel=1, Color_Sel=1)
    measure_latency(lat);
    check_val("press_latency", lat, 2 + D);
    step(1'b0, 1'b1);
    check_val("coinc_color", int'(bus.Color_Sel), 1);
    check_val("coinc_next", int'(bus.Next_Sel), 2);
    step(1'b0, 1'b1);
    check_val("coinc_color2", int'(bus.Color_Sel), 2);
    repeat (10) step(1'b1, 1'b0);

    // release bounce inside HELD
    repeat (8) step(1'b0, 1'b0);
    check_val("rb_held", int'(bus.Key_Held), 1);
    check_val("rb_wrap_next", int'(bus.Next_Sel), 0);
    p0 = pulse_seen;
    repeat (2) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    check_val("rb_no_pulse", pulse_seen - p0, 0);
    check_val("rb_held2", int'(bus.Key_Held), 1);
    repeat (8) step(1'b1, 1'b0);

    // reset two cycles into PRESS_WAIT with Key held low
    repeat (5) step(1'b0, 1'b0);
    check_val("mid_state_pw", int'(bus.Dbg_State), 1);
    do_reset();
    p0 = pulse_seen;
    measure_latency(lat);
    check_val("rst_latency", lat, 2 + D);
    repeat (12) step(1'b0, 1'b0);
    check_val("rst_one_pulse", pulse_seen - p0, 1);
    repeat (8) step(1'b1, 1'b0);

    // wrap / accumulate without Frame_Start
    do_reset();
    press_release();
    check_val("wrap_next1", int'(bus.Next_Sel), 1);
    press_release();
    check_val("wrap_next2", int'(bus.Next_Sel), 2);
    press_release();
    check_val("wrap_next0", int'(bus.Next_Sel), 0);
    check_val("wrap_color_hold", int'(bus.Color_Sel), 0);
    step(1'b1, 1'b1);
    check_val("wrap_color", int'(bus.Color_Sel), 0);

    // randomized runs against the model
    for (int blk = 0; blk < 400; blk++) begin
      level = $urandom_range(0, 1);
      len = $urandom_range(1, 10);
      if ($urandom_range(0, 99) == 0) begin
        bus.Key = level[0];
        do_reset();
      end
      for (int c = 0; c < len; c++) begin
        step(level[0], $urandom_range(0, 7) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
